// File: rtl/edge_event_scheduler.sv
// Multi-channel rising-edge event scheduler: latches input posedges as pending
// events and serialises them round-robin onto a valid/ready port. Optional
// input synchroniser enabled by defining EDGE_EVT_SYNC_EN.
module edge_event_scheduler #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    ip,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    input  logic            evt_ready,
    output logic [N-1:0]    ovf,
    input  logic            ovf_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    ip_s;
    logic [N-1:0]    ip_q;
    logic [N-1:0]    rise;
    logic [N-1:0]    pend, pend_nxt;
    logic [N-1:0]    ovf_set, ovf_nxt;
    logic [N-1:0]    load_mask;
    logic [ID_W-1:0] last_id, last_id_nxt;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] id_nxt;
    logic            valid_nxt;
    logic            load;
    logic            win_found;
    int unsigned     cand;

`ifdef EDGE_EVT_SYNC_EN
    logic [N-1:0] sync1, sync2;

    // Two-flop synchroniser for asynchronous level inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ip;
            sync2 <= sync1;
        end
    end

    assign ip_s = sync2;
`else
    assign ip_s = ip;
`endif

    assign rise = ip_s & ~ip_q;

    // Round-robin search starting one past the last granted channel
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(last_id) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!win_found && pend[cand]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand);
            end
        end
    end

    // Next-state and output-register logic
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    load      = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (evt_ready) begin
                    if (|pend) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        valid_nxt   = (state_nxt == VALID);
        id_nxt      = load ? win_id : evt_id;
        last_id_nxt = load ? win_id : last_id;
    end

    // A rise on a channel that is being loaded re-arms it rather than overflowing
    always_comb begin
        load_mask = load ? (N'(1) << win_id) : '0;
        pend_nxt  = (pend & ~load_mask) | rise;
        ovf_set   = rise & pend & ~load_mask;
        ovf_nxt   = (ovf_clr ? '0 : ovf) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ip_q      <= '0;
            pend      <= '0;
            ovf       <= '0;
            last_id   <= ID_W'(N - 1);
            evt_valid <= 1'b0;
            evt_id    <= '0;
        end else begin
            state     <= state_nxt;
            ip_q      <= ip_s;
            pend      <= pend_nxt;
            ovf       <= ovf_nxt;
            last_id   <= last_id_nxt;
            evt_valid <= valid_nxt;
            evt_id    <= id_nxt;
        end
    end

endmodule
